// File: rtl/dma_pkg.sv
// Shared types and default widths for the DMA loopback controller and its interface.
package dma_pkg;
    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_SIZE_WIDTH = 17;
    localparam int DEF_DATA_WIDTH = 512;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/dma_loopback_ctrl_if.sv
// Bundle of the memory-map request/done signals and the HAL DMA read/write channel signals.
interface dma_loopback_ctrl_if
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  go;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [SIZE_WIDTH-1:0] size;
    logic                  done;

    logic                  dma_rd_go;
    logic [ADDR_WIDTH-1:0] dma_rd_addr;
    logic [SIZE_WIDTH-1:0] dma_rd_size;
    logic                  dma_rd_en;
    logic [DATA_WIDTH-1:0] dma_rd_data;
    logic                  dma_rd_empty;

    logic                  dma_wr_go;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [SIZE_WIDTH-1:0] dma_wr_size;
    logic                  dma_wr_en;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic                  dma_wr_full;
    logic                  dma_wr_done;

    // master: the controller; slave: memory map plus DMA channels around it
    modport master (
        input  go, rd_addr, wr_addr, size,
        input  dma_rd_data, dma_rd_empty, dma_wr_full, dma_wr_done,
        output done,
        output dma_rd_go, dma_rd_addr, dma_rd_size, dma_rd_en,
        output dma_wr_go, dma_wr_addr, dma_wr_size, dma_wr_en, dma_wr_data
    );

    modport slave (
        output go, rd_addr, wr_addr, size,
        output dma_rd_data, dma_rd_empty, dma_wr_full, dma_wr_done,
        input  done,
        input  dma_rd_go, dma_rd_addr, dma_rd_size, dma_rd_en,
        input  dma_wr_go, dma_wr_addr, dma_wr_size, dma_wr_en, dma_wr_data
    );
endinterface

// File: rtl/dma_pipe_reg.sv
// One-entry pipeline register between the read FIFO head and the write FIFO input.
module dma_pipe_reg #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  unload,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] dout
);
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    // A load in the same cycle as an unload replaces the entry and keeps it valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= din;
        end else if (unload) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign dout  = data_reg;
endmodule

// File: rtl/dma_loopback_ctrl.sv
// Launches matching DMA read and write streams and copies each line from the read FIFO
// to the write FIFO through a one-entry register, raising done once the writes commit.
module dma_loopback_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic              clk,
    input logic              rst,
    dma_loopback_ctrl_if.master bus
);
    localparam logic [SIZE_WIDTH-1:0] CNT_ONE = SIZE_WIDTH'(1);

    state_t                state_reg, state_next;
    logic [SIZE_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;
    logic [SIZE_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;
    logic [SIZE_WIDTH-1:0] size_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, wr_addr_reg;
    logic                  done_reg;

    logic                  accept_go;
    logic                  rd_en;
    logic                  wr_en;
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    dma_pipe_reg #(.DATA_WIDTH(DATA_WIDTH)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .load   (rd_en),
        .unload (wr_en),
        .din    (bus.dma_rd_data),
        .valid  (pipe_valid),
        .dout   (pipe_data)
    );

    // The pipe only ever holds data during XFER, so the push needs no state qualifier
    assign wr_en = pipe_valid && !bus.dma_wr_full;
    assign rd_en = (state_reg == XFER) && !bus.dma_rd_empty
                   && (!pipe_valid || wr_en) && (rd_cnt_reg != size_reg);
    assign accept_go = bus.go && ((state_reg == IDLE) || (state_reg == DONE));

    always_comb begin
        state_next  = state_reg;
        rd_cnt_next = rd_cnt_reg;
        wr_cnt_next = wr_cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept_go) begin
                    rd_cnt_next = '0;
                    wr_cnt_next = '0;
                    state_next  = (bus.size == '0) ? DONE : START;
                end
            end
            START: state_next = XFER;
            XFER: begin
                if (rd_en) rd_cnt_next = rd_cnt_reg + CNT_ONE;
                if (wr_en) wr_cnt_next = wr_cnt_reg + CNT_ONE;
                if (wr_cnt_next == size_reg) state_next = DRAIN;
            end
            DRAIN: begin
                if (bus.dma_wr_done) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rd_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
            size_reg    <= '0;
            rd_addr_reg <= '0;
            wr_addr_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_cnt_reg <= rd_cnt_next;
            wr_cnt_reg <= wr_cnt_next;
            done_reg   <= (state_next == DONE);
            if (accept_go) begin
                rd_addr_reg <= bus.rd_addr;
                wr_addr_reg <= bus.wr_addr;
                size_reg    <= bus.size;
            end
        end
    end

    assign bus.done        = done_reg;
    assign bus.dma_rd_go   = (state_reg == START);
    assign bus.dma_wr_go   = (state_reg == START);
    assign bus.dma_rd_addr = rd_addr_reg;
    assign bus.dma_wr_addr = wr_addr_reg;
    assign bus.dma_rd_size = size_reg;
    assign bus.dma_wr_size = size_reg;
    assign bus.dma_rd_en   = rd_en;
    assign bus.dma_wr_en   = wr_en;
    assign bus.dma_wr_data = pipe_data;
endmodule

// File: tb/tb_dma_loopback_ctrl.sv
// Bench for dma_loopback_ctrl: table-driven transfers with a data scoreboard, plus
// hand sequences for zero size, reset mid-transfer and a full-range short-width build.
module tb_dma_loopback_ctrl;
    import dma_pkg::*;

    localparam int AW = 64;
    localparam int SW = 17;
    localparam int DW = 512;
    localparam int SAW = 16;
    localparam int SSW = 4;
    localparam int SDW = 32;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_loopback_ctrl_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) bus ();
    dma_loopback_ctrl_if #(.ADDR_WIDTH(SAW), .SIZE_WIDTH(SSW), .DATA_WIDTH(SDW)) sbus ();

    dma_loopback_ctrl #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dma_loopback_ctrl #(.ADDR_WIDTH(SAW), .SIZE_WIDTH(SSW), .DATA_WIDTH(SDW)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    typedef struct {
        int          sz;
        logic [31:0] base;
        bit          full_tog;
        int          empty_pct;
        bit          inject_go;
        bit          chk_consec;
    } vec_t;

    vec_t         tbl [5];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return bus.done | bus.dma_rd_go | bus.dma_wr_go | bus.dma_rd_en | bus.dma_wr_en
             | (|bus.dma_rd_addr) | (|bus.dma_wr_addr) | (|bus.dma_rd_size)
             | (|bus.dma_wr_size) | (|bus.dma_wr_data);
    endfunction

    task automatic issue_go(input int sz, input logic [AW-1:0] ra, input logic [AW-1:0] wa);
        @(negedge clk);
        bus.go           = 1'b1;
        bus.rd_addr      = ra;
        bus.wr_addr      = wa;
        bus.size         = SW'(sz);
        bus.dma_rd_empty = 1'b1;
        bus.dma_wr_full  = 1'b0;
        bus.dma_wr_done  = 1'b0;
        @(negedge clk);
        bus.go = 1'b0;
        #1;
        if (sz == 0) begin
            check("zero_done", DW'(bus.done), DW'(1));
            check("zero_no_go", DW'({bus.dma_rd_go, bus.dma_wr_go}), DW'(0));
        end else begin
            check("go_pulse", DW'({bus.dma_rd_go, bus.dma_wr_go}), DW'(2'b11));
            check("done_clr", DW'(bus.done), DW'(0));
            check("rd_addr", DW'(bus.dma_rd_addr), DW'(ra));
            check("wr_addr", DW'(bus.dma_wr_addr), DW'(wa));
            check("size", DW'({bus.dma_rd_size, bus.dma_wr_size}), DW'({SW'(sz), SW'(sz)}));
        end
    endtask

    // Runs one transfer; abort_at > 0 returns right after that many pushes are seen
    task automatic run_xfer(input int sz, input logic [31:0] base, input bit full_tog,
                            input int empty_pct, input bit inject_go, input bit chk_consec,
                            input int abort_at);
        int pushes = 0;
        int pops = 0;
        int gos = 0;
        int first_push = -1;
        int last_push = -1;
        int wd_cyc = -1;
        int done_cyc = -1;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] line;
        logic [DW-1:0] expv;
        logic [31:0]   w;
        ra = AW'(base) << 6;
        wa = ra + AW'(64'h10_0000);
        for (int i = 0; i < sz; i++) begin
            w = base + 32'(i);
            line = {(DW/32){w}};
            src_q.push_back(line);
            exp_q.push_back(line);
        end
        issue_go(sz, ra, wa);
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            bus.go           = inject_go && (cyc == 4);
            bus.rd_addr      = (inject_go && cyc == 4) ? ~ra : ra;
            bus.wr_addr      = (inject_go && cyc == 4) ? ~wa : wa;
            bus.size         = (inject_go && cyc == 4) ? SW'(sz + 3) : SW'(sz);
            bus.dma_wr_full  = full_tog && (cyc % 2 == 1);
            bus.dma_rd_empty = (src_q.size() == 0) || ($urandom_range(99) < empty_pct);
            bus.dma_rd_data  = (src_q.size() != 0) ? src_q[0] : '0;
            bus.dma_wr_done  = (pushes == sz) && (cyc >= last_push + 3);
            #1;
            if (bus.dma_rd_go || bus.dma_wr_go) gos++;
            check("rd_en_when_empty", DW'(bus.dma_rd_en & bus.dma_rd_empty), DW'(0));
            check("wr_en_when_full", DW'(bus.dma_wr_en & bus.dma_wr_full), DW'(0));
            if (bus.dma_rd_en) begin
                if (src_q.size() != 0) void'(src_q.pop_front());
                pops++;
            end
            if (bus.dma_wr_en) begin
                expv = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                check("wr_data", bus.dma_wr_data, expv);
                if (first_push < 0) first_push = cyc;
                last_push = cyc;
                pushes++;
            end
            if (bus.dma_wr_done && wd_cyc < 0) wd_cyc = cyc;
            if (abort_at > 0 && pushes == abort_at) begin
                $display("[TB] xfer size=%0d aborted after %0d pushes", sz, pushes);
                return;
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        bus.go = 1'b0;
        bus.dma_wr_done = 1'b0;
        check("done_seen", DW'(done_cyc >= 0), DW'(1));
        check("done_latency", DW'(done_cyc), DW'(wd_cyc + 1));
        check("push_count", DW'(pushes), DW'(sz));
        check("pop_count", DW'(pops), DW'(sz));
        check("scoreboard_left", DW'(exp_q.size()), DW'(0));
        check("extra_go", DW'(gos), DW'(0));
        if (chk_consec) check("consecutive", DW'(last_push - first_push), DW'(sz - 1));
        if (inject_go) begin
            check("rd_addr_kept", DW'(bus.dma_rd_addr), DW'(ra));
            check("size_kept", DW'(bus.dma_rd_size), DW'(SW'(sz)));
        end
        $display("[TB] xfer size=%0d base=%0h pushes=%0d pops=%0d done_cyc=%0d",
                 sz, base, pushes, pops, done_cyc);
    endtask

    initial begin
        int spush;
        int sidx;
        int sdone;
        tbl[0] = '{sz: 4, base: 32'hA0,  full_tog: 1'b0, empty_pct: 0,  inject_go: 1'b0, chk_consec: 1'b1};
        tbl[1] = '{sz: 8, base: 32'h100, full_tog: 1'b1, empty_pct: 30, inject_go: 1'b0, chk_consec: 1'b0};
        tbl[2] = '{sz: 6, base: 32'h200, full_tog: 1'b1, empty_pct: 0,  inject_go: 1'b0, chk_consec: 1'b0};
        tbl[3] = '{sz: 5, base: 32'h300, full_tog: 1'b0, empty_pct: 50, inject_go: 1'b1, chk_consec: 1'b0};
        tbl[4] = '{sz: 1, base: 32'h400, full_tog: 1'b0, empty_pct: 0,  inject_go: 1'b0, chk_consec: 1'b1};

        rst = 1'b1;
        bus.go = 1'b0; bus.rd_addr = '0; bus.wr_addr = '0; bus.size = '0;
        bus.dma_rd_data = '0; bus.dma_rd_empty = 1'b1; bus.dma_wr_full = 1'b0; bus.dma_wr_done = 1'b0;
        sbus.go = 1'b0; sbus.rd_addr = '0; sbus.wr_addr = '0; sbus.size = '0;
        sbus.dma_rd_data = '0; sbus.dma_rd_empty = 1'b1; sbus.dma_wr_full = 1'b0; sbus.dma_wr_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", DW'(any_out()), DW'(0));
        rst = 1'b0;

        // Zero-length request from IDLE
        issue_go(0, 64'h1000, 64'h2000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("zero_quiet", DW'({bus.dma_rd_go, bus.dma_wr_go, bus.dma_rd_en, bus.dma_wr_en}), DW'(0));
        end
        check("zero_done_held", DW'(bus.done), DW'(1));
        $display("[TB] xfer size=0 done=%0d", bus.done);

        for (int t = 0; t < 5; t++)
            run_xfer(tbl[t].sz, tbl[t].base, tbl[t].full_tog, tbl[t].empty_pct,
                     tbl[t].inject_go, tbl[t].chk_consec, 0);

        // Reset in the middle of a transfer, then a normal short transfer
        run_xfer(6, 32'h500, 1'b0, 0, 1'b0, 1'b0, 3);
        rst = 1'b1;
        #1;
        check("reset_mid_outputs", DW'(any_out()), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        run_xfer(2, 32'h600, 1'b0, 0, 1'b0, 1'b1, 0);

        // Short-width build at its maximum size
        @(negedge clk);
        sbus.go = 1'b1; sbus.size = SSW'(15); sbus.rd_addr = 16'h1240; sbus.wr_addr = 16'h5680;
        @(negedge clk);
        sbus.go = 1'b0;
        spush = 0; sidx = 0; sdone = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            sbus.dma_rd_empty = (sidx >= 15);
            sbus.dma_rd_data  = SDW'(32'hC0 + 32'(sidx));
            sbus.dma_wr_full  = 1'b0;
            sbus.dma_wr_done  = (spush == 15);
            #1;
            if (sbus.dma_rd_en) sidx++;
            if (sbus.dma_wr_en) begin
                check("s_wr_data", DW'(sbus.dma_wr_data), DW'(32'hC0 + 32'(spush)));
                spush++;
            end
            if (sbus.done) begin
                sdone = 1;
                break;
            end
        end
        sbus.dma_wr_done = 1'b0;
        check("s_done", DW'(sdone), DW'(1));
        check("s_pushes", DW'(spush), DW'(15));
        check("s_pops", DW'(sidx), DW'(15));
        check("s_size", DW'(sbus.dma_rd_size), DW'(15));
        $display("[TB] xfer small size=15 pushes=%0d done=%0d", spush, sdone);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
